// File: rtl/pcoder_arbiter_if.sv
// pcoder_arbiter_if: requester-bank to arbiter handshake bundle
interface pcoder_arbiter_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic [7:0] hold_cnt;
  modport master (output en, req, input gnt, gnt_id, gnt_valid, hold_cnt);
  modport slave (input en, req, output gnt, gnt_id, gnt_valid, hold_cnt);
endinterface

// File: rtl/pcoder_arbiter.sv
// pcoder_arbiter: 8-way round-robin arbiter with bounded tenure
module pcoder_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic             clk,
  input logic             rst_n,
  pcoder_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);
  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx, owner, owner_nx, win;
  logic [7:0] grant, grant_nx, hold, hold_nx, cand;
  logic       owner_req, take;
  function automatic logic [2:0] search(input logic [7:0] v, input logic [2:0] p);
    logic [7:0] r;
    logic [2:0] k;
    r = 8'({v, v} >> p);
    k = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (r[i]) k = 3'(i);
    return p + k;
  endfunction
  // the owner is excluded here; at timeout ptr = owner+1 already makes it lowest priority
  assign owner_req = state == GRANT && bus.req[owner];
  assign cand      = bus.req & ~grant;
  assign win       = search(cand, ptr);
  assign take      = bus.en && |cand && (!owner_req || hold == LAST);
  always_comb begin
    state_nx = (take || owner_req) ? GRANT : IDLE;
    owner_nx = take ? win : owner_req ? owner : 3'd0;
    hold_nx  = (take || !owner_req || hold == LAST) ? 8'd0 : hold + 8'd1;
    ptr_nx   = take ? win + 3'd1 : ptr;
    grant_nx = state_nx == GRANT ? 8'(1) << owner_nx : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      owner <= 3'd0;
      grant <= 8'd0;
      hold  <= 8'd0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
      grant <= grant_nx;
      hold  <= hold_nx;
    end
  end
  assign bus.gnt       = grant;
  assign bus.gnt_id    = owner;
  assign bus.gnt_valid = state == GRANT;
  assign bus.hold_cnt  = hold;
endmodule
